bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_countdown_timer.sv | 155 +++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with one-second prescaler, pause/resume,
// optional auto-reload on expiry and invalid-load detection.
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned MIN_DIGITS  = 2,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    CE,
  input  logic [4*MIN_DIGITS-1:0] din_min,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] min_bcd,
  output logic                    tick,
  output logic                    done,
  output logic                    error,
  output logic [2:0]              state
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned   MW        = 4 * MIN_DIGITS;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      ones_q, ones_d, tens_q, tens_d;
  logic [MW-1:0]   min_q, min_d, stored_q, stored_d, min_dec;
  logic [PW-1:0]   presc_q, presc_d;
  logic            pulse_q, pulse_d;
  logic            din_bad, count_zero, last_sec, presc_wrap;

  always_comb begin
    din_bad = 1'b0;
    for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
      if (din_min[4*i +: 4] > 4'd9) din_bad = 1'b1;
    end
  end

  // Minute digits after a borrow out of the seconds field.
  always_comb begin
    logic borrow;
    min_dec = min_q;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
      if (borrow) begin
        if (min_q[4*i +: 4] == 4'd0) begin
          min_dec[4*i +: 4] = 4'd9;
        end else begin
          min_dec[4*i +: 4] = min_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  assign count_zero = (min_q == '0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign last_sec   = (min_q == '0) && (tens_q == 4'd0) && (ones_q == 4'd1);
  assign presc_wrap = (presc_q == PRESC_MAX);

  // A load in the same cycle swallows the pending decrement, so tick follows it.
  assign tick = (state_q == RUN) && presc_wrap && !load;

  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    tens_d   = tens_q;
    min_d    = min_q;
    stored_d = stored_q;
    presc_d  = presc_q;
    pulse_d  = 1'b0;
    if (load) begin
      presc_d = '0;
      ones_d  = '0;
      tens_d  = '0;
      if (din_bad) begin
        min_d   = '0;
        state_d = ERROR;
      end else begin
        stored_d = din_min;
        min_d    = din_min;
        state_d  = (din_min == '0) ? DONE : IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE:  if (CE && !count_zero) state_d = RUN;
        PAUSE: if (CE) state_d = RUN;
        RUN: begin
          state_d = CE ? RUN : PAUSE;
          if (presc_wrap) begin
            presc_d = '0;
            if (last_sec) begin
              ones_d = '0;
              if (AUTO_RELOAD != 0) begin
                min_d   = stored_q;
                pulse_d = 1'b1;
              end else begin
                state_d = DONE;
              end
            end else if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              if (tens_q != 4'd0) begin
                tens_d = tens_q - 4'd1;
              end else begin
                tens_d = 4'd5;
                min_d  = min_dec;
              end
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ones_q   <= '0;
      tens_q   <= '0;
      min_q    <= '0;
      stored_q <= '0;
      presc_q  <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      tens_q   <= tens_d;
      min_q    <= min_d;
      stored_q <= stored_d;
      presc_q  <= presc_d;
      pulse_q  <= pulse_d;
    end
  end

  assign sec_ones = ones_q;
  assign sec_tens = tens_q;
  assign min_bcd  = min_q;
  assign state    = state_q;
  assign done     = (state_q == DONE) || pulse_q;
  assign error    = (state_q == ERROR);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two instances (stop / auto-reload) checked
// against a seconds-level reference model plus directed scenario constants.
module tb_bcd_countdown_timer;

  localparam int TD = 4;
  localparam int MD = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3, S_ERR = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic ce = 1'b0;
  logic [4*MD-1:0] din = '0;

  logic [3:0]      ones0, tens0, ones1, tens1;
  logic [4*MD-1:0] min0, min1;
  logic            tick0, done0, err0, tick1, done1, err1;
  logic [2:0]      st0, st1;
  logic [21:0]     obs0, obs1;

  assign obs0 = {st0, done0, err0, tick0, min0, tens0, ones0};
  assign obs1 = {st1, done1, err1, tick1, min1, tens1, ones1};

  bcd_countdown_timer #(.TICK_DIV(TD), .MIN_DIGITS(MD), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .CE(ce), .din_min(din),
    .sec_ones(ones0), .sec_tens(tens0), .min_bcd(min0),
    .tick(tick0), .done(done0), .error(err0), .state(st0)
  );

  bcd_countdown_timer #(.TICK_DIV(TD), .MIN_DIGITS(MD), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .CE(ce), .din_min(din),
    .sec_ones(ones1), .sec_tens(tens1), .min_bcd(min1),
    .tick(tick1), .done(done1), .error(err1), .state(st1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: remaining time held as plain seconds, run progress as a phase count.
  typedef struct {
    int st;
    int total;
    int stored;
    int phase;
    bit pulse;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = S_IDLE; m.total = 0; m.stored = 0; m.phase = 0; m.pulse = 1'b0;
    return m;
  endfunction

  function automatic bit din_ok(logic [7:0] d);
    return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9);
  endfunction

  function automatic int din_dec(logic [7:0] d);
    return int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit ar, bit ld, bit c, logic [7:0] d);
    mdl_t n = m;
    n.pulse = 1'b0;
    if (ld) begin
      n.phase = 0;
      if (!din_ok(d)) begin
        n.total = 0;
        n.st    = S_ERR;
      end else begin
        n.stored = din_dec(d);
        n.total  = n.stored * 60;
        n.st     = (n.stored == 0) ? S_DONE : S_IDLE;
      end
    end else begin
      case (m.st)
        S_IDLE:  if (c && m.total != 0) n.st = S_RUN;
        S_PAUSE: if (c) n.st = S_RUN;
        S_RUN: begin
          n.st = c ? S_RUN : S_PAUSE;
          if (m.phase == TD - 1) begin
            n.phase = 0;
            n.total = m.total - 1;
            if (n.total == 0) begin
              if (ar) begin
                n.total = m.stored * 60;
                n.pulse = 1'b1;
              end else begin
                n.st = S_DONE;
              end
            end
          end else begin
            n.phase = m.phase + 1;
          end
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [21:0] vec(int st, bit dn, bit er, bit tk, logic [7:0] mm, logic [7:0] ss);
    return {3'(st), dn, er, tk, mm, ss};
  endfunction

  function automatic logic [21:0] mexp(mdl_t m, bit ld);
    int mm, ss;
    logic [7:0] mb, sb;
    mm = m.total / 60;
    ss = m.total % 60;
    mb = {4'(mm / 10), 4'(mm % 10)};
    sb = {4'(ss / 10), 4'(ss % 10)};
    return vec(m.st, (m.st == S_DONE) || m.pulse, m.st == S_ERR,
               (m.st == S_RUN) && (m.phase == TD - 1) && !ld, mb, sb);
  endfunction

  task automatic clk_step();
    @(posedge clk);
    m0 = mstep(m0, 1'b0, load, ce, din);
    m1 = mstep(m1, 1'b1, load, ce, din);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; ce = 1'b1; din = 8'h45;
    repeat (2) @(posedge clk);
    #2;
    n_tests++; if (obs0 !== '0) begin n_fail++; $display("FAIL reset_hold dut0: got %h want 0", obs0); end
    n_tests++; if (obs1 !== '0) begin n_fail++; $display("FAIL reset_hold dut1: got %h want 0", obs1); end
    load = 1'b0; reset = 1'b0;
    m0 = mreset(); m1 = mreset();
    for (int i = 0; i < 6; i++) begin
      clk_step();
      n_tests++; if (obs0 !== vec(S_IDLE, 0, 0, 0, 8'h00, 8'h00)) begin n_fail++; $display("FAIL reset_idle_ce dut0: got %h want %h", obs0, vec(S_IDLE, 0, 0, 0, 8'h00, 8'h00)); end
      n_tests++; if (obs1 !== vec(S_IDLE, 0, 0, 0, 8'h00, 8'h00)) begin n_fail++; $display("FAIL reset_idle_ce dut1: got %h want %h", obs1, vec(S_IDLE, 0, 0, 0, 8'h00, 8'h00)); end
    end
    ce = 1'b0;
  endtask

  task automatic test_countdown();
    int ticks = 0;
    int first_change = -1;
    int cyc = 0;
    din = 8'h02; load = 1'b1; clk_step(); load = 1'b0;
    n_tests++; if (obs0 !== vec(S_IDLE, 0, 0, 0, 8'h02, 8'h00)) begin n_fail++; $display("FAIL load_02: got %h want %h", obs0, vec(S_IDLE, 0, 0, 0, 8'h02, 8'h00)); end
    ce = 1'b1; clk_step();
    n_tests++; if (st0 !== 3'(S_RUN)) begin n_fail++; $display("FAIL enter_run: got %0d want %0d", st0, S_RUN); end
    while (st0 == 3'(S_RUN) && cyc < 120 * TD + 20) begin
      n_tests++; if (obs0 !== mexp(m0, load)) begin n_fail++; $display("FAIL countdown_model dut0 cyc %0d: got %h want %h", cyc, obs0, mexp(m0, load)); end
      n_tests++; if (obs1 !== mexp(m1, load)) begin n_fail++; $display("FAIL countdown_model dut1 cyc %0d: got %h want %h", cyc, obs1, mexp(m1, load)); end
      if (first_change < 0 && {min0, tens0, ones0} != 16'h0200) begin
        first_change = cyc;
        n_tests++; if ({min0, tens0, ones0} !== 16'h0159) begin n_fail++; $display("FAIL first_decrement: got %h want 0159", {min0, tens0, ones0}); end
      end
      if (tick0 === 1'b1) ticks++;
      clk_step();
      cyc++;
    end
    n_tests++; if (first_change != TD) begin n_fail++; $display("FAIL first_tick_latency: got %0d want %0d", first_change, TD); end
    n_tests++; if (ticks != 120) begin n_fail++; $display("FAIL tick_count: got %0d want 120", ticks); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (obs0 !== vec(S_DONE, 1, 0, 0, 8'h00, 8'h00)) begin n_fail++; $display("FAIL done_hold: got %h want %h", obs0, vec(S_DONE, 1, 0, 0, 8'h00, 8'h00)); end
      ce = 1'($urandom_range(0, 1));
      clk_step();
    end
    ce = 1'b0;
  endtask

  task automatic test_minute_borrow();
    int cyc = 0;
    din = 8'h10; load = 1'b1; ce = 1'b0; clk_step(); load = 1'b0; ce = 1'b1;
    while (tick0 !== 1'b1 && cyc < 3 * TD) begin clk_step(); cyc++; end
    n_tests++; if (tick0 !== 1'b1) begin n_fail++; $display("FAIL borrow_tick_wait: got %b want 1", tick0); end
    clk_step();
    n_tests++; if ({min0, tens0, ones0} !== 16'h0959) begin n_fail++; $display("FAIL minute_borrow: got %h want 0959", {min0, tens0, ones0}); end
    ce = 1'b0;
  endtask

  task automatic test_error_load();
    din = 8'hA3; load = 1'b1; clk_step(); load = 1'b0;
    n_tests++; if (obs0 !== vec(S_ERR, 0, 1, 0, 8'h00, 8'h00)) begin n_fail++; $display("FAIL error_load dut0: got %h want %h", obs0, vec(S_ERR, 0, 1, 0, 8'h00, 8'h00)); end
    n_tests++; if (obs1 !== vec(S_ERR, 0, 1, 0, 8'h00, 8'h00)) begin n_fail++; $display("FAIL error_load dut1: got %h want %h", obs1, vec(S_ERR, 0, 1, 0, 8'h00, 8'h00)); end
    ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clk_step();
      n_tests++; if (obs0 !== vec(S_ERR, 0, 1, 0, 8'h00, 8'h00)) begin n_fail++; $display("FAIL error_hold: got %h want %h", obs0, vec(S_ERR, 0, 1, 0, 8'h00, 8'h00)); end
    end
    din = 8'h01; load = 1'b1; ce = 1'b0; clk_step(); load = 1'b0;
    n_tests++; if (obs0 !== vec(S_IDLE, 0, 0, 0, 8'h01, 8'h00)) begin n_fail++; $display("FAIL error_recover: got %h want %h", obs0, vec(S_IDLE, 0, 0, 0, 8'h01, 8'h00)); end
    din = 8'h3B; load = 1'b1; clk_step(); load = 1'b0;
    n_tests++; if (obs0 !== vec(S_ERR, 0, 1, 0, 8'h00, 8'h00)) begin n_fail++; $display("FAIL error_low_nibble: got %h want %h", obs0, vec(S_ERR, 0, 1, 0, 8'h00, 8'h00)); end
  endtask

  task automatic test_pause_resume();
    din = 8'h05; load = 1'b1; clk_step(); load = 1'b0;
    ce = 1'b1; clk_step();
    n_tests++; if (st0 !== 3'(S_RUN)) begin n_fail++; $display("FAIL pause_run_start: got %0d want %0d", st0, S_RUN); end
    clk_step();
    ce = 1'b0; clk_step();
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (obs0 !== vec(S_PAUSE, 0, 0, 0, 8'h05, 8'h00)) begin n_fail++; $display("FAIL pause_hold %0d: got %h want %h", i, obs0, vec(S_PAUSE, 0, 0, 0, 8'h05, 8'h00)); end
      clk_step();
    end
    ce = 1'b1; clk_step();
    n_tests++; if (obs0 !== vec(S_RUN, 0, 0, 0, 8'h05, 8'h00)) begin n_fail++; $display("FAIL resume_cycle0: got %h want %h", obs0, vec(S_RUN, 0, 0, 0, 8'h05, 8'h00)); end
    clk_step();
    n_tests++; if (obs0 !== vec(S_RUN, 0, 0, 1, 8'h05, 8'h00)) begin n_fail++; $display("FAIL resume_tick: got %h want %h", obs0, vec(S_RUN, 0, 0, 1, 8'h05, 8'h00)); end
    clk_step();
    n_tests++; if (obs0 !== vec(S_RUN, 0, 0, 0, 8'h04, 8'h59)) begin n_fail++; $display("FAIL resume_decrement: got %h want %h", obs0, vec(S_RUN, 0, 0, 0, 8'h04, 8'h59)); end
    ce = 1'b0;
  endtask

  task automatic test_auto_reload();
    int cyc = 0;
    din = 8'h01; load = 1'b1; clk_step(); load = 1'b0; ce = 1'b1;
    while (done1 !== 1'b1 && cyc < 60 * TD + 20) begin clk_step(); cyc++; end
    n_tests++; if (obs1 !== vec(S_RUN, 1, 0, 0, 8'h01, 8'h00)) begin n_fail++; $display("FAIL reload_pulse: got %h want %h", obs1, vec(S_RUN, 1, 0, 0, 8'h01, 8'h00)); end
    n_tests++; if (obs0 !== vec(S_DONE, 1, 0, 0, 8'h00, 8'h00)) begin n_fail++; $display("FAIL stop_expiry: got %h want %h", obs0, vec(S_DONE, 1, 0, 0, 8'h00, 8'h00)); end
    clk_step();
    n_tests++; if (obs1 !== vec(S_RUN, 0, 0, 0, 8'h01, 8'h00)) begin n_fail++; $display("FAIL reload_pulse_end: got %h want %h", obs1, vec(S_RUN, 0, 0, 0, 8'h01, 8'h00)); end
    repeat (TD - 2) clk_step();
    n_tests++; if (obs1 !== vec(S_RUN, 0, 0, 1, 8'h01, 8'h00)) begin n_fail++; $display("FAIL reload_tick: got %h want %h", obs1, vec(S_RUN, 0, 0, 1, 8'h01, 8'h00)); end
    clk_step();
    n_tests++; if (obs1 !== vec(S_RUN, 0, 0, 0, 8'h00, 8'h59)) begin n_fail++; $display("FAIL reload_next: got %h want %h", obs1, vec(S_RUN, 0, 0, 0, 8'h00, 8'h59)); end
    ce = 1'b0;
  endtask

  task automatic test_load_priority_reset();
    int cyc = 0;
    din = 8'h03; load = 1'b1; clk_step(); load = 1'b0; ce = 1'b1;
    while (tick0 !== 1'b1 && cyc < 3 * TD) begin clk_step(); cyc++; end
    n_tests++; if (tick0 !== 1'b1) begin n_fail++; $display("FAIL prio_tick_wait: got %b want 1", tick0); end
    din = 8'h07; load = 1'b1; clk_step(); load = 1'b0;
    n_tests++; if (obs0 !== vec(S_IDLE, 0, 0, 0, 8'h07, 8'h00)) begin n_fail++; $display("FAIL load_over_tick: got %h want %h", obs0, vec(S_IDLE, 0, 0, 0, 8'h07, 8'h00)); end
    clk_step();
    cyc = 0;
    while (tick0 !== 1'b1 && cyc < 3 * TD) begin clk_step(); cyc++; end
    n_tests++; if (cyc != TD - 1) begin n_fail++; $display("FAIL prio_presc_cleared: got %0d want %0d", cyc, TD - 1); end
    clk_step();
    #2;
    reset = 1'b1;
    #1;
    n_tests++; if (obs0 !== '0) begin n_fail++; $display("FAIL async_reset dut0: got %h want 0", obs0); end
    n_tests++; if (obs1 !== '0) begin n_fail++; $display("FAIL async_reset dut1: got %h want 0", obs1); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (obs0 !== '0) begin n_fail++; $display("FAIL reset_held: got %h want 0", obs0); end
    reset = 1'b0;
    m0 = mreset(); m1 = mreset();
    for (int i = 0; i < 4; i++) begin
      clk_step();
      n_tests++; if (obs0 !== vec(S_IDLE, 0, 0, 0, 8'h00, 8'h00)) begin n_fail++; $display("FAIL post_reset_idle dut0: got %h want %h", obs0, vec(S_IDLE, 0, 0, 0, 8'h00, 8'h00)); end
      n_tests++; if (obs1 !== vec(S_IDLE, 0, 0, 0, 8'h00, 8'h00)) begin n_fail++; $display("FAIL post_reset_idle dut1: got %h want %h", obs1, vec(S_IDLE, 0, 0, 0, 8'h00, 8'h00)); end
    end
    ce = 1'b0;
  endtask

  task automatic test_random(int n);
    for (int i = 0; i < n; i++) begin
      int r;
      if ($urandom_range(0, 999) < 3) begin
        reset = 1'b1; load = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m0 = mreset(); m1 = mreset();
      end
      load = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 9);
      if (r < 6)      din = {4'h0, 4'($urandom_range(0, 2))};
      else if (r < 8) din = 8'h10;
      else            din = 8'($urandom_range(0, 255));
      ce = ($urandom_range(0, 99) < 85);
      #1;
      n_tests++; if (obs0 !== mexp(m0, load)) begin n_fail++; $display("FAIL random dut0 step %0d: got %h want %h", i, obs0, mexp(m0, load)); end
      n_tests++; if (obs1 !== mexp(m1, load)) begin n_fail++; $display("FAIL random dut1 step %0d: got %h want %h", i, obs1, mexp(m1, load)); end
      clk_step();
    end
    load = 1'b0; ce = 1'b0;
  endtask

  initial begin
    m0 = mreset();
    m1 = mreset();
    test_reset();
    test_countdown();
    test_minute_borrow();
    test_error_load();
    test_pause_resume();
    test_auto_reload();
    test_load_priority_reset();
    test_random(4000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
